// File: rtl/alu_sequencer.sv
// Issue-side controller for a combinational ALU: accepts an instruction, reads the
// operands from a local register file, drives the ALU, captures and writes back the result.
module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_ra,
  input  logic [AW-1:0]    in_rb,
  input  logic             in_imm_en,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_z,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_data,
  output logic [AW-1:0]    done_rd,
  output logic             z_flag
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t           state, state_next;
  logic [4:0]       op_q;
  logic [AW-1:0]    rd_q, ra_q, rb_q;
  logic             imm_en_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] rf [NREGS];
  logic             accept_c;

  assign accept_c = in_valid & in_ready;

  // Next-state decode; WRITE holds until the consumer takes the result
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      done_valid <= 1'b0;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_cin    <= 1'b0;
      done_data  <= '0;
      done_rd    <= '0;
      z_flag     <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else begin
      state      <= state_next;
      in_ready   <= (state_next == IDLE);
      done_valid <= (state_next == WRITE);

      if (accept_c) begin
        op_q     <= in_op;
        rd_q     <= in_rd;
        ra_q     <= in_ra;
        rb_q     <= in_rb;
        imm_en_q <= in_imm_en;
        imm_q    <= in_imm;
      end

      // Preload port is only live while idle, so it never races the write-back
      if (state == IDLE && ext_we) rf[ext_addr] <= ext_data;

      if (state == READ) begin
        alu_a   <= rf[ra_q];
        alu_b   <= imm_en_q ? imm_q : rf[rb_q];
        alu_sel <= op_q[4:1];
        alu_cin <= op_q[0];
      end

      // Write-back lands on the edge entering WRITE, together with the result capture
      if (state == EXEC) begin
        done_data <= alu_res;
        done_rd   <= rd_q;
        z_flag    <= alu_z;
        rf[rd_q]  <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_op = '0;
  logic [2:0] in_rd = '0, in_ra = '0, in_rb = '0;
  logic       in_imm_en = 1'b0;
  logic [7:0] in_imm = '0;
  logic       ext_we = 1'b0;
  logic [2:0] ext_addr = '0;
  logic [7:0] ext_data = '0;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [3:0] alu_sel;
  logic       alu_cin, alu_z;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [7:0] done_data;
  logic [2:0] done_rd;
  logic       z_flag;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
    logic       z;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [8];
  int         vectors = 0;
  int         miscompares = 0;

  alu_sequencer #(.WIDTH(8), .NREGS(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_z(alu_z), .done_valid(done_valid), .done_ready(done_ready),
    .done_data(done_data), .done_rd(done_rd), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  // Small reference ALU; undecoded codes give 0 (and therefore Z=1)
  function automatic logic [7:0] f_alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      5'b00000: return a;
      5'b00001: return 8'(a + 8'd1);
      5'b00010: return 8'(a + b);
      5'b00011: return 8'(a + b + 8'd1);
      5'b01100: return a ^ b;
      default:  return 8'h00;
    endcase
  endfunction

  assign alu_res = f_alu({alu_sel, alu_cin}, alu_a, alu_b);
  assign alu_z   = (alu_res == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    mdl[a] = d;
    @(posedge clk); #1;
    ext_we = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic imm_en, input logic [7:0] imm,
                       input logic ext_en, input logic [2:0] ea, input logic [7:0] ed,
                       input int stall);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
    in_imm_en = imm_en; in_imm = imm;
    ext_we = ext_en; ext_addr = ea; ext_data = ed;
    if (ext_en) mdl[ea] = ed;
    e.a = mdl[ra];
    e.b = imm_en ? imm : mdl[rb];
    e.op = op;
    e.rd = rd;
    e.data = f_alu(op, e.a, e.b);
    e.z = (e.data == 8'h00);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; ext_we = 1'b0;
    done_ready = (stall == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_valid && lat < 10);
    chk("latency", 32'(lat), 32'd3);
    if (!done_valid) begin
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk("done_data", 32'(done_data), 32'(e.data));
    chk("done_rd", 32'(done_rd), 32'(e.rd));
    chk("z_flag", 32'(z_flag), 32'(e.z));
    chk("alu_a", 32'(alu_a), 32'(e.a));
    chk("alu_b", 32'(alu_b), 32'(e.b));
    chk("alu_op", 32'({alu_sel, alu_cin}), 32'(e.op));
    mdl[e.rd] = e.data;
    for (int i = 0; i < stall; i++) begin
      if (i == 0) begin
        ext_we = 1'b1; ext_addr = 3'd3; ext_data = 8'hAA;
      end else begin
        ext_we = 1'b0;
      end
      @(negedge clk);
      chk("stall_valid", 32'(done_valid), 32'd1);
      chk("stall_data", 32'(done_data), 32'(e.data));
      chk("stall_rd", 32'(done_rd), 32'(e.rd));
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    ext_we = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(done_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
    done_ready = 1'b0;
  endtask

  // Transfer op (A passthrough) exposes a register-file entry as the result
  task automatic peek(input logic [2:0] r);
    issue(5'b00000, r, r, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_z_flag", 32'(z_flag), 32'd0);
    chk("rst_done_data", 32'(done_data), 32'd0);
    chk("rst_done_rd", 32'(done_rd), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
    peek(3'd0);
    peek(3'd5);

    preload(3'd1, 8'h05);
    preload(3'd2, 8'h03);
    issue(5'b00010, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0);
    peek(3'd3);

    issue(5'b01100, 3'd4, 3'd1, 3'd0, 1'b1, 8'h05, 1'b0, 3'd0, 8'h00, 0);

    preload(3'd1, 8'hFF);
    issue(5'b00001, 3'd1, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0);
    peek(3'd1);

    // Same-cycle preload and accept on the operand register
    issue(5'b00010, 3'd5, 3'd2, 3'd2, 1'b0, 8'h00, 1'b1, 3'd2, 8'h40, 0);
    issue(5'b00011, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0);
    issue(5'b11110, 3'd6, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0);

    // Back-pressure with an ignored preload during WRITE
    issue(5'b00010, 3'd7, 3'd5, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 5);
    peek(3'd3);

    // Reset in EXEC aborts the instruction
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h03);
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'b00010; in_rd = 3'd3; in_ra = 3'd1; in_rb = 3'd2; in_imm_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_valid", 32'(done_valid), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
    end
    chk("abort_z", 32'(z_flag), 32'd0);
    chk("abort_data", 32'(done_data), 32'd0);
    peek(3'd3);
    peek(3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
